meter_display: RTL and testbench
================================

METER_DISPLAY -- requirements
Module: meter_display

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk frequency in Hz; sets the blink timebase.
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles each digit is enabled per multiplex slot.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port mode  input  2  display mode from meter input stage: 0 blank, 1 solid, 2 blink 0.5 Hz, 3 blink 1 Hz.
REQ-006 Port tval  input  14  remaining time, binary; values >9999 treated as 9999.
REQ-007 Port seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 Port an  output  4  digit enables, active-low; an[0] ones digit, an[3] thousands digit.
REQ-009 Port dp  output  1  decimal point, active-low; constant 1 (off).

Function
REQ-010 Converter FSM states: IDLE, CONV, LOAD.
- IDLE: every cycle, capture min(tval,9999) into the shift register and go to CONV.
- CONV: 14 double-dabble iterations, one per cycle (add 3 to any BCD nibble >=5, then shift left 1).
- LOAD: copy the 4 BCD nibbles into the display digit register, then go to IDLE.
REQ-011 Latency: tval sampled in IDLE at edge N appears in the digit register at edge N+15; the register updates only in LOAD, never partially.
REQ-012 tval changes during CONV or LOAD are ignored until the next IDLE sample.
REQ-013 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap the digit index advances 0->1->2->3->0.
REQ-014 Exactly one an bit is low at any time when the display is lit; the low bit is an[index].
REQ-015 seg equals the active-low 7-segment pattern of the digit-register nibble selected by index; digits 0-9 only.
REQ-016 Blink counter counts clk cycles; half-period is CLK_HZ/2 cycles for mode 3 and CLK_HZ cycles for mode 2; the lit flag toggles at each half-period end.
REQ-017 A change of mode, detected against a registered copy, clears the blink counter and sets lit=1 in the same cycle.
REQ-018 Mode 1: lit is forced to 1. Mode 0: display is blanked.
REQ-019 Blanked or lit=0: an=4'b1111 and seg=7'b1111111; the refresh and converter logic keep running.
REQ-020 All outputs are registered; no combinational path runs from tval or mode to the outputs.

Reset
REQ-021 While rst=1 at a clk edge, the following are cleared: converter FSM to IDLE, shift register and digit register to 0, refresh counter and index to 0, blink counter to 0, lit to 1, registered mode to 0.
REQ-022 Outputs after reset: an=4'b1111, seg=7'b1111111, dp=1.
REQ-023 Reset asserted mid-conversion discards the conversion; the digit register reads 0.

Configuration
REQ-024 Macro METER_DISPLAY_LZB_EN enables leading-zero blanking.
- Defined: any digit above the most significant non-zero digit drives an high for its slot. The ones digit is never blanked, so 0 shows as "0" and 205 shows as " 205".
- Undefined: all four digits are always driven, so 205 shows as "0205".

Verification
REQ-025 Bench parameters: CLK_HZ=100, REFRESH_DIV=4.
REQ-026 Scenario: rst for 2 cycles, then tval=1234, mode=1 -> from cycle 16 onward, an cycles 1110,1101,1011,0111 every 4 cycles with seg = codes for 4,3,2,1.
REQ-027 Scenario: tval=12000, mode=1 -> display reads 9999.
REQ-028 Scenario: tval=205, mode=3 -> lit for 50 cycles, dark (an=1111) for 50 cycles, repeating; mode switched to 2 mid-dark -> lit immediately, then 100 cycles lit / 100 cycles dark.
REQ-029 Scenario: tval=0, mode=0 -> an=1111 in every cycle; then mode=1 -> ones digit shows 0, and with METER_DISPLAY_LZB_EN the other three slots have an high.
REQ-030 Scenario: tval changes 1234->5678 at cycle 3 of CONV -> digit register holds 1234 first, then 5678 after the following conversion, with no mixed digits at any time.
REQ-031 Scenario: rst pulsed during CONV -> next cycle an=1111, seg=1111111, digit register=0.

Source files
------------

// File: rtl/meter_display_if.sv
// rtl/meter_display_if.sv - meter display bus: mode/time inputs and digit/segment drive
interface meter_display_if;
    logic [1:0]  mode;
    logic [13:0] tval;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    modport master (output mode, output tval, input seg, input an, input dp);
    modport slave  (input mode, input tval, output seg, output an, output dp);
endinterface

// File: rtl/meter_display.sv
// rtl/meter_display.sv - 4-digit multiplexed 7-segment timer display with blink modes
// Optional leading-zero blanking: define METER_DISPLAY_LZB_EN.
module meter_display #(
    parameter int CLK_HZ      = 100000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    meter_display_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(CLK_HZ + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] HALF_FAST = BW'(CLK_HZ / 2 - 1);
    localparam logic [BW-1:0] HALF_SLOW = BW'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_t;

    conv_state_t r_state;
    logic [29:0] r_shift;
    logic [3:0]  r_iter;
    logic [15:0] r_digits;
    logic [RW-1:0] r_ref;
    logic [1:0]  r_idx;
    logic [BW-1:0] r_blink;
    logic        r_lit;
    logic [1:0]  r_mode;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic [BW-1:0] w_half_m1;
    logic [3:0]    w_nibble;
    logic          w_lead_blank;

    // One double-dabble iteration: BCD field in [29:14], binary in [13:0].
    function automatic logic [29:0] dd_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5)
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_iter   <= '0;
            r_digits <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_shift <= {16'd0, (bus.tval > 14'd9999) ? 14'd9999 : bus.tval};
                    r_iter  <= '0;
                    r_state <= CONV;
                end
                CONV: begin
                    r_shift <= dd_step(r_shift);
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd13)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_digits <= r_shift[29:14];
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == REF_LAST) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    assign w_half_m1 = r_mode[0] ? HALF_FAST : HALF_SLOW;

    // Mode 2/3 blink; a fresh mode always restarts the lit half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= 2'd0;
            r_blink <= '0;
            r_lit   <= 1'b1;
        end else if (bus.mode != r_mode) begin
            r_mode  <= bus.mode;
            r_blink <= '0;
            r_lit   <= 1'b1;
        end else if (r_mode[1]) begin
            if (r_blink == w_half_m1) begin
                r_blink <= '0;
                r_lit   <= ~r_lit;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end else begin
            r_blink <= '0;
            r_lit   <= 1'b1;
        end
    end

    assign w_nibble = r_digits[4*r_idx +: 4];

    always_comb begin
        w_lead_blank = 1'b0;
`ifdef METER_DISPLAY_LZB_EN
        case (r_idx)
            2'd3:    w_lead_blank = (r_digits[15:12] == 4'd0);
            2'd2:    w_lead_blank = (r_digits[15:8] == 8'd0);
            2'd1:    w_lead_blank = (r_digits[15:4] == 12'd0);
            default: w_lead_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        r_dp <= 1'b1;
        if (rst || r_mode == 2'd0 || !r_lit || w_lead_blank) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= seg_code(w_nibble);
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
endmodule

// File: tb/tb_meter_display.sv
// tb/tb_meter_display.sv - randomized bench for meter_display against an arithmetic reference model
module tb_meter_display;
    localparam int CLK_HZ = 100;
    localparam int RD     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    meter_display_if bus ();

    meter_display #(.CLK_HZ(CLK_HZ), .REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Active-high gfedcba patterns for decimal digits.
    logic [6:0] seg_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int  m_t, m_pend, m_val, m_since;
    int  m_rmode;
    bit  m_valid = 0;
    logic [11:0] exp_out;
    logic [15:0] exp_bcd;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, expv);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [11:0] model_out();
        int  idx, half, d;
        bit  lit, blank;
        logic [6:0] sg;
        idx  = (m_t / RD) % 4;
        half = (m_rmode == 3) ? CLK_HZ / 2 : CLK_HZ;
        lit  = (m_rmode <= 1) ? 1'b1 : (((m_since / half) % 2) == 0);
        blank = (m_rmode == 0) || !lit;
`ifdef METER_DISPLAY_LZB_EN
        if (idx > 0 && m_val < pow10(idx)) blank = 1'b1;
`endif
        if (blank) return {4'b1111, 7'b1111111, 1'b1};
        d  = (m_val / pow10(idx)) % 10;
        sg = ~seg_on[d];
        return {~(4'b0001 << idx), sg, 1'b1};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            exp_out = {4'b1111, 7'b1111111, 1'b1};
            m_t = 0; m_pend = 0; m_val = 0; m_since = 0; m_rmode = 0;
        end else if (m_valid) begin
            exp_out = model_out();
            m_t++;
            if ((m_t - 1) % 16 == 0) m_pend = (int'(bus.tval) > 9999) ? 9999 : int'(bus.tval);
            if (m_t % 16 == 0) m_val = m_pend;
            if (int'(bus.mode) != m_rmode) begin
                m_rmode = int'(bus.mode);
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        exp_bcd = {4'(m_val / 1000 % 10), 4'(m_val / 100 % 10), 4'(m_val / 10 % 10), 4'(m_val % 10)};
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_eq("an_seg_dp", {4'd0, bus.an, bus.seg, bus.dp}, {4'd0, exp_out});
            check_eq("digit_reg", dut.r_digits, exp_bcd);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 32; i++) begin
            if (m_t % 16 == ph) break;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.mode = 2'd1;
        bus.tval = 14'd1234;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(60);

        bus.tval = 14'd12000;
        cycles(40);

        bus.tval = 14'd205;
        bus.mode = 2'd3;
        cycles(75);
        bus.mode = 2'd2;
        cycles(260);

        bus.tval = 14'd0;
        bus.mode = 2'd0;
        cycles(40);
        bus.mode = 2'd1;
        cycles(40);

        bus.tval = 14'd1234;
        cycles(34);
        wait_phase(4);
        bus.tval = 14'd5678;
        cycles(40);

        wait_phase(6);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(40);

        for (int s = 0; s < 30; s++) begin
            bus.tval = 14'($urandom_range(0, 16383));
            bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
            cycles($urandom_range(1, 120));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
